// File: rtl/sdc_blk_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdc_blk_arb_if
//  Description : Block-request bundle between the two-drive SD controller,
//                the block arbiter and the single MiSTer host block port.
//  Revision    : 1.0  initial release
// ============================================================================
interface sdc_blk_arb_if;
    // controller side
    logic [1:0]  drv_rd;
    logic [1:0]  drv_wr;
    logic [31:0] drv_lba0;
    logic [31:0] drv_lba1;
    logic [1:0]  drv_ack;
    logic [8:0]  drv_buff_addr;
    logic [7:0]  drv_buff_dout;
    logic        drv_buff_wr;
    logic [7:0]  drv_buff_din0;
    logic [7:0]  drv_buff_din1;
    // host side
    logic        hps_rd;
    logic        hps_wr;
    logic [31:0] hps_lba;
    logic        hps_ack;
    logic [8:0]  hps_buff_addr;
    logic [7:0]  hps_buff_dout;
    logic [7:0]  hps_buff_din;
    logic        hps_buff_wr;
    // status
    logic        busy;
    logic        cur_drive;
    logic        timeout;

    // arbiter view
    modport master (
        input  drv_rd, drv_wr, drv_lba0, drv_lba1, drv_buff_din0, drv_buff_din1,
        input  hps_ack, hps_buff_addr, hps_buff_dout, hps_buff_wr,
        output drv_ack, drv_buff_addr, drv_buff_dout, drv_buff_wr,
        output hps_rd, hps_wr, hps_lba, hps_buff_din,
        output busy, cur_drive, timeout
    );

    // controller + host view
    modport slave (
        output drv_rd, drv_wr, drv_lba0, drv_lba1, drv_buff_din0, drv_buff_din1,
        output hps_ack, hps_buff_addr, hps_buff_dout, hps_buff_wr,
        input  drv_ack, drv_buff_addr, drv_buff_dout, drv_buff_wr,
        input  hps_rd, hps_wr, hps_lba, hps_buff_din,
        input  busy, cur_drive, timeout
    );
endinterface
`default_nettype wire

// File: rtl/sdc_blk_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sdc_blk_arb
//  Description : Round-robin merge of two drive block-request channels onto
//                one host block port, with LBA latch and ack watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module sdc_blk_arb #(
    parameter int                   TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd4000000
) (
    input  wire logic      CLK,
    input  wire logic      RESET,
    sdc_blk_arb_if.master  bus
);

    localparam logic [TIMEOUT_W-1:0] c_one        = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] c_count_last = TIMEOUT_CYCLES - c_one;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } t_state;

    t_state               r_state;
    logic                 r_last_served;
    logic [TIMEOUT_W-1:0] r_count;
    logic                 r_hps_rd;
    logic                 r_hps_wr;
    logic [31:0]          r_hps_lba;
    logic                 r_cur_drive;
    logic                 r_timeout;

    logic [1:0]           w_req;
    logic                 w_grant;
    logic                 w_g_rd;
    logic                 w_g_wr;
    logic [31:0]          w_g_lba;
    logic                 w_active;

    assign w_req   = bus.drv_rd | bus.drv_wr;
    // Tie goes to the drive that was not served last.
    assign w_grant = (w_req == 2'b11) ? ~r_last_served : w_req[1];
    assign w_g_rd  = w_grant ? bus.drv_rd[1]   : bus.drv_rd[0];
    assign w_g_wr  = w_grant ? bus.drv_wr[1]   : bus.drv_wr[0];
    assign w_g_lba = w_grant ? bus.drv_lba1    : bus.drv_lba0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_last_served <= 1'b1;
            r_count       <= '0;
            r_hps_rd      <= 1'b0;
            r_hps_wr      <= 1'b0;
            r_hps_lba     <= 32'd0;
            r_cur_drive   <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A lingering host ack (after reset or timeout) blocks new grants.
                    if (!bus.hps_ack && (w_req != 2'b00)) begin
                        r_cur_drive <= w_grant;
                        r_hps_lba   <= w_g_lba;
                        r_hps_rd    <= w_g_rd;
                        r_hps_wr    <= w_g_wr & ~w_g_rd;
                        r_count     <= '0;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.hps_ack) begin
                        r_hps_rd <= 1'b0;
                        r_hps_wr <= 1'b0;
                        r_state  <= S_XFER;
                    end else if (r_count == c_count_last) begin
                        r_hps_rd  <= 1'b0;
                        r_hps_wr  <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_count <= r_count + c_one;
                    end
                end
                S_XFER: begin
                    if (!bus.hps_ack) begin
                        r_last_served <= r_cur_drive;
                        r_state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_active = (r_state == S_REQ) || (r_state == S_XFER);

    assign bus.drv_ack       = !w_active   ? 2'b00
                             : r_cur_drive ? {bus.hps_ack, 1'b0}
                             :               {1'b0, bus.hps_ack};
    assign bus.drv_buff_addr = bus.hps_buff_addr;
    assign bus.drv_buff_dout = bus.hps_buff_dout;
    assign bus.drv_buff_wr   = bus.hps_buff_wr & bus.hps_ack & w_active;
    // Controller buffer read data is already registered; plain mux only.
    assign bus.hps_buff_din  = !w_active   ? 8'd0
                             : r_cur_drive ? bus.drv_buff_din1
                             :               bus.drv_buff_din0;

    assign bus.hps_rd    = r_hps_rd;
    assign bus.hps_wr    = r_hps_wr;
    assign bus.hps_lba   = r_hps_lba;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.cur_drive = r_cur_drive;
    assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sdc_blk_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdc_blk_arb
//  Description : Directed bench for sdc_blk_arb with a grant scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdc_blk_arb;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    sdc_blk_arb_if bus();

    sdc_blk_arb #(
        .TIMEOUT_W      (24),
        .TIMEOUT_CYCLES (24'd16)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic        drive;
        logic [31:0] lba;
        logic        rd;
        logic        wr;
    } exp_t;
    exp_t sb[$];

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic d, input logic [31:0] l, input logic r, input logic w);
        exp_t e;
        e.drive = d; e.lba = l; e.rd = r; e.wr = w;
        sb.push_back(e);
    endtask

    // Wait (bounded) for a host request, then check it against the scoreboard.
    task automatic wait_grant(input string tag, output int n, output bit saw_idle);
        exp_t e;
        n = 0;
        saw_idle = 1'b0;
        while (n < 40) begin
            tick;
            n++;
            if (!bus.busy) saw_idle = 1'b1;
            if (bus.hps_rd || bus.hps_wr) break;
        end
        chk({tag, "_granted"}, {63'd0, bus.hps_rd | bus.hps_wr}, 64'd1);
        chk({tag, "_sb_nonempty"}, {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_drive"}, {63'd0, bus.cur_drive}, {63'd0, e.drive});
            chk({tag, "_lba"},   {32'd0, bus.hps_lba},   {32'd0, e.lba});
            chk({tag, "_rd"},    {63'd0, bus.hps_rd},    {63'd0, e.rd});
            chk({tag, "_wr"},    {63'd0, bus.hps_wr},    {63'd0, e.wr});
        end
    endtask

    // Host acks, streams nbytes, then releases ack; the drive drops its request on ack.
    task automatic xfer(input string tag, input logic g, input int nbytes);
        int         wr_cnt, ack_bad, pass_bad, din_bad;
        logic [1:0] ack_exp;
        logic [7:0] d0, d1, dexp;
        wr_cnt = 0; ack_bad = 0; pass_bad = 0; din_bad = 0;
        ack_exp = g ? 2'b10 : 2'b01;
        bus.hps_ack = 1'b1;
        tick;
        chk({tag, "_req_drop"}, {63'd0, bus.hps_rd | bus.hps_wr}, 64'd0);
        bus.drv_rd[g] = 1'b0;
        bus.drv_wr[g] = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            d0 = i[7:0] ^ 8'h3C;
            d1 = ~i[7:0];
            bus.hps_buff_wr   = 1'b1;
            bus.hps_buff_addr = i[8:0];
            bus.hps_buff_dout = i[7:0] ^ 8'h5A;
            bus.drv_buff_din0 = d0;
            bus.drv_buff_din1 = d1;
            #1;
            dexp = g ? d1 : d0;
            if (bus.drv_buff_wr === 1'b1) wr_cnt++;
            if (bus.drv_ack !== ack_exp) ack_bad++;
            if (bus.drv_buff_addr !== i[8:0] || bus.drv_buff_dout !== (i[7:0] ^ 8'h5A)) pass_bad++;
            if (bus.hps_buff_din !== dexp) din_bad++;
            tick;
        end
        bus.hps_buff_wr = 1'b0;
        bus.hps_ack     = 1'b0;
        chk({tag, "_buff_wr_pulses"}, wr_cnt,   nbytes);
        chk({tag, "_ack_route_bad"},  ack_bad,  0);
        chk({tag, "_passthru_bad"},   pass_bad, 0);
        chk({tag, "_din_route_bad"},  din_bad,  0);
        tick;
        chk({tag, "_done_busy"}, {63'd0, bus.busy}, 64'd1);
        chk({tag, "_done_ack"},  {62'd0, bus.drv_ack}, 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hps_rd"},    {63'd0, bus.hps_rd},    64'd0);
        chk({tag, "_hps_wr"},    {63'd0, bus.hps_wr},    64'd0);
        chk({tag, "_hps_lba"},   {32'd0, bus.hps_lba},   64'd0);
        chk({tag, "_cur_drive"}, {63'd0, bus.cur_drive}, 64'd0);
        chk({tag, "_busy"},      {63'd0, bus.busy},      64'd0);
        chk({tag, "_timeout"},   {63'd0, bus.timeout},   64'd0);
        chk({tag, "_drv_ack"},   {62'd0, bus.drv_ack},   64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, errors=%0d", errs);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, k;
        bit si, rd_held;

        RESET = 1'b1;
        bus.drv_rd = 2'b00;  bus.drv_wr = 2'b00;
        bus.drv_lba0 = '0;   bus.drv_lba1 = '0;
        bus.drv_buff_din0 = '0; bus.drv_buff_din1 = '0;
        bus.hps_ack = 1'b0;  bus.hps_buff_addr = '0;
        bus.hps_buff_dout = '0; bus.hps_buff_wr = 1'b0;
        tick; tick;
        RESET = 1'b0;
        chk_reset_vals("rst");

        // single read on drive 0, full 512-byte stream
        bus.drv_lba0 = 32'h12;
        bus.drv_rd   = 2'b01;
        push(1'b0, 32'h12, 1'b1, 1'b0);
        wait_grant("t1", n, si);
        chk("t1_latency", n, 1);
        chk("t1_busy", {63'd0, bus.busy}, 64'd1);
        xfer("t1", 1'b0, 512);
        tick;
        bus.hps_buff_wr = 1'b1;
        #1;
        chk("idle_buff_wr_gated", {63'd0, bus.drv_buff_wr}, 64'd0);
        chk("idle_busy", {63'd0, bus.busy}, 64'd0);
        bus.hps_buff_wr = 1'b0;

        // simultaneous requests after reset, then round-robin
        RESET = 1'b1; tick; RESET = 1'b0;
        bus.drv_lba0 = 32'h100;
        bus.drv_lba1 = 32'h200;
        bus.drv_rd   = 2'b11;
        push(1'b0, 32'h100, 1'b1, 1'b0);
        push(1'b1, 32'h200, 1'b1, 1'b0);
        wait_grant("t2a", n, si);
        chk("t2a_latency", n, 1);
        xfer("t2a", 1'b0, 4);
        wait_grant("t2b", n, si);
        chk("t2b_gap", n, 2);
        chk("t2b_idle_seen", {63'd0, si}, 64'd1);
        xfer("t2b", 1'b1, 4);
        bus.drv_rd = 2'b11;
        push(1'b0, 32'h100, 1'b1, 1'b0);
        push(1'b1, 32'h200, 1'b1, 1'b0);
        wait_grant("t2c", n, si);
        chk("t2c_idle_seen", {63'd0, si}, 64'd1);
        xfer("t2c", 1'b0, 4);
        wait_grant("t2d", n, si);
        xfer("t2d", 1'b1, 4);

        // write on drive 1, LBA changes after grant are ignored
        bus.drv_lba1 = 32'hABC;
        bus.drv_wr   = 2'b10;
        push(1'b1, 32'hABC, 1'b0, 1'b1);
        wait_grant("t3", n, si);
        bus.drv_lba1 = 32'h0;
        tick; tick;
        chk("t3_lba_held", {32'd0, bus.hps_lba}, 64'hABC);
        chk("t3_hps_wr",   {63'd0, bus.hps_wr},  64'd1);
        chk("t3_hps_rd",   {63'd0, bus.hps_rd},  64'd0);
        xfer("t3", 1'b1, 16);

        // watchdog expiry and retry
        bus.drv_lba0 = 32'h55;
        bus.drv_rd   = 2'b01;
        push(1'b0, 32'h55, 1'b1, 1'b0);
        wait_grant("t4", n, si);
        k = 0;
        rd_held = 1'b1;
        while (bus.timeout !== 1'b1 && k < 40) begin
            if (bus.hps_rd !== 1'b1) rd_held = 1'b0;
            tick;
            k++;
        end
        chk("t4_expiry_cycles", k, 16);
        chk("t4_rd_held", {63'd0, rd_held}, 64'd1);
        chk("t4_rd_dropped", {63'd0, bus.hps_rd}, 64'd0);
        push(1'b0, 32'h55, 1'b1, 1'b0);
        wait_grant("t4_retry", n, si);
        chk("t4_retry_latency", n, 1);
        chk("t4_timeout_pulse", {63'd0, bus.timeout}, 64'd0);
        xfer("t4", 1'b0, 4);

        // reset in the middle of a transfer with ack still high
        bus.drv_lba1 = 32'h77;
        bus.drv_rd   = 2'b10;
        push(1'b1, 32'h77, 1'b1, 1'b0);
        wait_grant("t5", n, si);
        bus.hps_ack = 1'b1;
        tick; tick;
        bus.drv_lba0 = 32'h66;
        bus.drv_rd   = 2'b01;
        RESET = 1'b1;
        tick;
        RESET = 1'b0;
        chk_reset_vals("t5_rst");
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t5_stale_ack_rd",   {63'd0, bus.hps_rd}, 64'd0);
            chk("t5_stale_ack_busy", {63'd0, bus.busy},   64'd0);
        end
        bus.hps_ack = 1'b0;
        push(1'b0, 32'h66, 1'b1, 1'b0);
        wait_grant("t5_after", n, si);
        chk("t5_after_latency", n, 1);
        xfer("t5", 1'b0, 4);

        // read and write together on one drive: read wins
        bus.drv_lba0 = 32'h99;
        bus.drv_rd   = 2'b01;
        bus.drv_wr   = 2'b01;
        push(1'b0, 32'h99, 1'b1, 1'b0);
        wait_grant("t6", n, si);
        xfer("t6", 1'b0, 2);
        tick; tick;

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdc_blk_arb.md
Name: sdc_blk_arb

Overview:
- Sits directly downstream of the CoCo3 SD controller's block-level request interface.
- Merges the controller's two per-drive request channels onto the single MiSTer host block port: read/write strobes, LBA, ack, and the 512-byte buffer byte stream.
- Arbitrates fairly between drive 0 and drive 1, latches the LBA at grant, and routes the host ack and buffer traffic to the granted drive only.
- A timeout watchdog recovers the port when the host never acks.

Parameters:
TIMEOUT_W, 24, width of timeout counter
TIMEOUT_CYCLES, 24'd4000000, CLK cycles in REQ without hps_ack before abandoning the request

Ports:
CLK  in  1  system clock; all state updates on rising edge
RESET  in  1  synchronous, active-high reset
drv_rd  in  2  per-drive read request (level, held until ack)
drv_wr  in  2  per-drive write request (level, held until ack)
drv_lba0  in  32  drive 0 block address
drv_lba1  in  32  drive 1 block address
drv_ack  out  2  per-drive ack; only granted bit may be 1
drv_buff_addr  out  9  buffer byte address to controller
drv_buff_dout  out  8  host-to-controller byte
drv_buff_wr  out  1  host-to-controller byte write strobe
drv_buff_din0  in  8  controller-to-host byte, drive 0
drv_buff_din1  in  8  controller-to-host byte, drive 1
hps_rd  out  1  host read request
hps_wr  out  1  host write request
hps_lba  out  32  latched block address
hps_ack  in  1  host ack (high for whole transfer)
hps_buff_addr  in  9  host buffer address
hps_buff_dout  in  8  host data out
hps_buff_din  out  8  data to host
hps_buff_wr  in  1  host byte write strobe
busy  out  1  high in any state other than IDLE
cur_drive  out  1  granted drive index
timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset values:
  - hps_rd=0, hps_wr=0, hps_lba=0, cur_drive=0, busy=0, timeout=0.
  - Internal last_served=1, so drive 0 wins the first tie. Timeout counter=0. State=IDLE.
- Reset mid-transfer: reset dominates. All of the above reset values apply at the next edge, and any in-flight host transfer is abandoned.
- FSM states: IDLE, REQ, XFER, DONE.
- IDLE:
  - Stays in IDLE while hps_ack=1 (stale ack after reset or timeout).
  - Otherwise req[i]=drv_rd[i]|drv_wr[i]. If exactly one is set, grant it. If both are set, grant drive !last_served.
  - At the grant edge: cur_drive<=g, hps_lba<=drv_lba[g], hps_rd<=drv_rd[g], hps_wr<=drv_wr[g]&~drv_rd[g] (read wins if both are set), counter<=0, state<=REQ.
  - hps_rd/hps_wr are visible the cycle after the request is first sampled.
- REQ:
  - If hps_ack=1: hps_rd<=0, hps_wr<=0, state<=XFER.
  - Else if counter==TIMEOUT_CYCLES-1: hps_rd<=0, hps_wr<=0, timeout<=1 for one cycle, state<=IDLE. The drive never sees an ack; a still-held request is re-granted, which acts as a retry.
  - Else counter<=counter+1.
  - drv_lba changes after the grant are ignored.
- XFER: when hps_ack=0, last_served<=cur_drive and state<=DONE.
- DONE: one cycle, state<=IDLE. This guarantees at least one idle cycle between transfers.
- Routing (combinational; valid in REQ and XFER, otherwise 0):
  - drv_ack[cur_drive]=hps_ack; drv_ack[!cur_drive]=0.
  - drv_buff_addr=hps_buff_addr and drv_buff_dout=hps_buff_dout, passed through unconditionally.
  - drv_buff_wr=hps_buff_wr & hps_ack while in REQ or XFER.
  - hps_buff_din=cur_drive ? drv_buff_din1 : drv_buff_din0. The controller's buffer supplies registered read data, so no extra pipelining is added here.
- Other rules:
  - Only one of hps_rd and hps_wr is ever high.
  - A request on the non-granted drive is held off, not dropped, until the FSM returns to IDLE.
  - The counter is TIMEOUT_W bits wide and never wraps: expiry exits REQ.

Test Plan:
1. Reset, then drv_rd=2'b01, drv_lba0=32'h12 -> next cycle hps_rd=1, hps_lba=32'h12, cur_drive=0. Host acks with 512 hps_buff_wr strobes -> drv_ack=2'b01 throughout, drv_buff_wr pulses 512 times, and drv_buff_wr stays 0 for drive 1.
2. drv_rd=2'b11 at the same edge after reset -> drive 0 served first, then drive 1. Repeat with both set after serving drive 1 -> drive 0 again (round-robin). At least one IDLE cycle between grants.
3. drv_wr[1]=1, drv_lba1=32'hABC; change drv_lba1 to 0 in REQ -> hps_wr=1, hps_rd=0, hps_lba stays 32'hABC. hps_buff_din tracks drv_buff_din1 during ack.
4. With TIMEOUT_CYCLES=16, drv_rd[0]=1 and hps_ack held 0 -> hps_rd drops and timeout pulses once, 16 cycles after REQ entry. The request is then re-issued.
5. RESET asserted mid-XFER with hps_ack=1 -> next cycle all outputs at reset values. No new hps_rd until hps_ack falls, even with drv_rd pending.
6. drv_rd[0]=drv_wr[0]=1 simultaneously -> hps_rd=1, hps_wr=0.
